ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue.sv | 113 +++++++++++
 tb/tb_ifetch_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues sequential word-aligned fetches and buffers up to DEPTH
// {instr, pc} entries for decode; a redirect flushes the queue and restarts fetch.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       fetch_en,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redir_valid,
  input  logic [XLEN-1:0]            redir_pc,
  output logic                       instr_valid,
  output logic [XLEN-1:0]            instr,
  output logic [XLEN-1:0]            instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CW:0]     CREDIT  = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic            inflight;
  logic            kill;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];

  logic [CW:0] used;
  logic        issue;
  logic        push;
  logic        pop;
  logic        unused_redir_lsbs;

  assign unused_redir_lsbs = ^redir_pc[1:0];

  // Credit check counts the in-flight response so a push never finds the queue full.
  always_comb begin
    used  = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue = RST & fetch_en & ~redir_valid & (used < CREDIT);
    push  = inflight & ~kill & ~redir_valid;
    pop   = instr_valid & instr_ready & ~redir_valid;
  end

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != {CW{1'b0}});
  assign instr       = mem_instr[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];

  // Fetch PC, response tracking, pointers and occupancy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      rd_ptr   <= {AW{1'b0}};
      wr_ptr   <= {AW{1'b0}};
      count    <= {CW{1'b0}};
    end else if (redir_valid) begin
      fetch_pc <= {redir_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      // A request launched alongside a redirect would belong to the old stream.
      kill     <= issue;
      rd_ptr   <= {AW{1'b0}};
      wr_ptr   <= {AW{1'b0}};
      count    <= {CW{1'b0}};
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
        resp_pc  <= fetch_pc;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
      kill <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1'b1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= {XLEN{1'b0}};
        mem_pc[i]    <= {XLEN{1'b0}};
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: stimulus pushes expected PCs into a scoreboard,
// a negedge monitor pops and compares on every decode handshake.
module tb_ifetch_queue;

  logic        CLK;
  logic        RST;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;

  logic        rst_w;
  logic        fetch_en_w;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic        redir_valid_w;
  logic [31:0] redir_pc_w;
  logic        instr_valid_w;
  logic [31:0] instr_w;
  logic [31:0] instr_pc_w;
  logic        instr_ready_w;
  logic [2:0]  count_w;

  int          nvec  = 0;
  int          nfail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] wrap_addr [4];

  ifetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .fetch_en(fetch_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .count(count)
  );

  ifetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .CLK(CLK), .RST(rst_w), .fetch_en(fetch_en_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .redir_valid(redir_valid_w), .redir_pc(redir_pc_w),
    .instr_valid(instr_valid_w), .instr(instr_w), .instr_pc(instr_pc_w),
    .instr_ready(instr_ready_w), .count(count_w)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // lw at even word indices, sw at odd ones, immediate = word index
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    return idx[0] ? {16'hAC01, idx[15:0]} : {16'h8C01, idx[15:0]};
  endfunction

  always @(posedge CLK) begin
    imem_rdata   <= imem_req   ? imem_word(imem_addr)   : 32'hDEAD_BEEF;
    imem_rdata_w <= imem_req_w ? imem_word(imem_addr_w) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_and_release();
    RST = 1'b0;
    repeat (2) step();
    exp_q.delete();
    step();
    RST = 1'b1;
  endtask

  // scoreboard monitor: a handshake coinciding with redirect is still consumed
  always @(negedge CLK) begin
    if (RST && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL sb_unexpected: got pc %h expected none", instr_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        chk("sb_pc", instr_pc, exp_pc);
        chk("sb_instr", instr, imem_word(exp_pc));
      end
    end
    if (redir_valid) exp_q.delete();
  end

  initial begin
    RST = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0;
    rst_w = 1'b0; fetch_en_w = 1'b1; instr_ready_w = 1'b0; redir_valid_w = 1'b0; redir_pc_w = 32'h0;
    wrap_addr[0] = 32'hFFFF_FFF8; wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000; wrap_addr[3] = 32'h0000_0004;

    // reset values and streaming
    repeat (2) step();
    @(negedge CLK);
    chk("rst_req", imem_req, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_count", count, 32'd0);
    step();
    RST = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      @(negedge CLK);
      chk("t1_req", imem_req, 32'd1);
      chk("t1_addr", imem_addr, 32'(4 * c));
      if (c < 2) chk("t1_valid_lo", instr_valid, 32'd0);
      if (c == 2) chk("t1_valid_hi", instr_valid, 32'd1);
    end
    step();
    RST = 1'b0;
    chk("t1_drain", exp_q.size(), 32'd0);

    // backpressure
    instr_ready = 1'b0;
    reset_and_release();
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      if (c == 8) instr_ready = 1'b1;
      @(negedge CLK);
      if (c < 4) begin
        chk("t2_req", imem_req, 32'd1);
        chk("t2_addr", imem_addr, 32'(4 * c));
      end
      if (c >= 4 && c <= 8) chk("t2_stall", imem_req, 32'd0);
      if (c == 4) chk("t2_count3", count, 32'd3);
      if (c == 7) chk("t2_full", count, 32'd4);
      if (c == 9) begin
        chk("t2_resume_req", imem_req, 32'd1);
        chk("t2_resume_addr", imem_addr, 32'h10);
      end
    end
    step();
    RST = 1'b0;
    chk("t2_drain", exp_q.size(), 32'd0);

    // redirect with response in flight, then unaligned redirect
    reset_and_release();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    @(negedge CLK);
    step(); @(negedge CLK);
    step(); @(negedge CLK);
    chk("t3_addr8", imem_addr, 32'h8);
    step();
    redir_valid = 1'b1; redir_pc = 32'h40;
    @(negedge CLK);
    chk("t3_redir_noreq", imem_req, 32'd0);
    step();
    redir_valid = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(32'h40 + 4 * k));
    @(negedge CLK);
    chk("t3_count0", count, 32'd0);
    chk("t3_empty", instr_valid, 32'd0);
    chk("t3_req", imem_req, 32'd1);
    chk("t3_addr40", imem_addr, 32'h40);
    step(); @(negedge CLK);
    chk("t3_addr44", imem_addr, 32'h44);
    chk("t3_valid_lo", instr_valid, 32'd0);
    step(); @(negedge CLK);
    chk("t3_valid_hi", instr_valid, 32'd1);
    repeat (4) step();
    redir_valid = 1'b1; redir_pc = 32'h43;
    @(negedge CLK);
    step();
    redir_valid = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(32'h40 + 4 * k));
    @(negedge CLK);
    chk("t4_addr", imem_addr, 32'h40);
    chk("t4_count0", count, 32'd0);
    repeat (5) step();
    RST = 1'b0;
    chk("t3_drain", exp_q.size(), 32'd0);

    // fetch stall then asynchronous mid-run reset
    reset_and_release();
    for (int k = 0; k < 7; k++) exp_q.push_back(32'(4 * k));
    for (int c = 0; c < 14; c++) begin
      if (c > 0) step();
      if (c == 3) fetch_en = 1'b0;
      if (c == 8) fetch_en = 1'b1;
      @(negedge CLK);
      if (c >= 3 && c <= 7) chk("t5_noreq", imem_req, 32'd0);
      if (c == 4) chk("t5_inflight_kept", instr_valid, 32'd1);
      if (c == 5) chk("t5_drained", count, 32'd0);
      if (c == 8) chk("t5_resume_addr", imem_addr, 32'hC);
    end
    step();
    chk("t5_drain", exp_q.size(), 32'd0);
    chk("t5_pre_valid", instr_valid, 32'd1);
    RST = 1'b0;
    #1;
    chk("t5_rst_valid", instr_valid, 32'd0);
    chk("t5_rst_count", count, 32'd0);
    chk("t5_rst_addr", imem_addr, 32'h0);
    chk("t5_rst_req", imem_req, 32'd0);

    // address wrap on the second instance
    step();
    rst_w = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      @(negedge CLK);
      if (c < 4) begin
        chk("t6_req", imem_req_w, 32'd1);
        chk("t6_addr", imem_addr_w, wrap_addr[c]);
      end
    end
    chk("t6_full_noreq", imem_req_w, 32'd0);
    chk("t6_full_count", count_w, 32'd4);
    chk("t6_head_pc", instr_pc_w, 32'hFFFF_FFF8);
    chk("t6_head_instr", instr_w, imem_word(32'hFFFF_FFF8));
    step();
    instr_ready_w = 1'b1;
    @(negedge CLK);
    step();
    @(negedge CLK);
    chk("t6_pc2", instr_pc_w, 32'hFFFF_FFFC);
    step();
    @(negedge CLK);
    chk("t6_pc3", instr_pc_w, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
